// File: rtl/sdram_refresh_arbiter.sv
// sdram_refresh_arbiter
// Shares the SDRAM command sequencer between Zorro II bus accesses and
// auto-refresh. Runs the power-up init sequence, tracks refresh debt and
// hides refreshes in bus-idle gaps, forcing one only when the debt is full.
module sdram_refresh_arbiter #(
  parameter int unsigned POWERUP_CYCLES   = 20000,
  parameter int unsigned INIT_REFRESHES   = 8,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned MAX_PENDING      = 8
) (
  input  logic       MEMCLK,
  input  logic       RESET_n,
  input  logic       bus_req,
  input  logic       cmd_done,
  output logic       cmd_start,
  output logic       cmd_refresh,
  output logic       bus_gnt,
  output logic       bus_ack,
  output logic       init_done,
  output logic [3:0] pending,
  output logic       ref_overrun
);

  localparam int unsigned PW_W = $clog2(POWERUP_CYCLES + 1);
  localparam int unsigned IN_W = $clog2(INIT_REFRESHES + 1);
  localparam int unsigned RI_W = $clog2(REFRESH_INTERVAL + 1);

  localparam logic [PW_W-1:0] PW_LAST  = PW_W'(POWERUP_CYCLES - 1);
  localparam logic [IN_W-1:0] IN_LAST  = IN_W'(INIT_REFRESHES - 1);
  localparam logic [RI_W-1:0] RI_LAST  = RI_W'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]      PEND_MAX = 4'(MAX_PENDING);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_REF,
    S_INIT_GAP,
    S_IDLE,
    S_BUS,
    S_REF
  } state_t;

  state_t          state_q, state_d;
  logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [IN_W-1:0] init_cnt_q, init_cnt_d;
  logic [RI_W-1:0] tmr_q, tmr_d;
  logic [3:0]      pend_q, pend_d;
  logic            ovr_q, ovr_d;
  logic            start_q, start_d;
  logic            refr_q, refr_d;
  logic            gnt_q, gnt_d;
  logic            ack_q, ack_d;
  logic            idone_q, idone_d;

  logic done_ok;
  logic tick;
  logic ref_done;

  // The sequencer cannot finish in the cycle it is started, so a cmd_done
  // coincident with our own cmd_start belongs to nothing and is dropped.
  assign done_ok  = cmd_done & ~start_q;
  assign tick     = idone_q & (tmr_q == RI_LAST);
  assign ref_done = (state_q == S_REF) & done_ok;

  // Next-state and command issue for the init / arbitration FSM.
  always_comb begin
    state_d    = state_q;
    pw_cnt_d   = pw_cnt_q;
    init_cnt_d = init_cnt_q;
    start_d    = 1'b0;
    refr_d     = 1'b0;
    gnt_d      = gnt_q;
    ack_d      = ack_q;
    idone_d    = idone_q;
    case (state_q)
      S_INIT_WAIT: begin
        if (pw_cnt_q == PW_LAST) begin
          state_d = S_INIT_REF;
          start_d = 1'b1;
          refr_d  = 1'b1;
        end else begin
          pw_cnt_d = pw_cnt_q + PW_W'(1);
        end
      end
      S_INIT_REF: begin
        if (done_ok) begin
          init_cnt_d = init_cnt_q + IN_W'(1);
          if (init_cnt_q == IN_LAST) begin
            idone_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_INIT_GAP;
          end
        end
      end
      S_INIT_GAP: begin
        state_d = S_INIT_REF;
        start_d = 1'b1;
        refr_d  = 1'b1;
      end
      S_IDLE: begin
        if (pend_q == PEND_MAX) begin
          state_d = S_REF;
          start_d = 1'b1;
          refr_d  = 1'b1;
        end else if (bus_req) begin
          state_d = S_BUS;
          start_d = 1'b1;
          gnt_d   = 1'b1;
        end else if (pend_q != 4'd0) begin
          state_d = S_REF;
          start_d = 1'b1;
          refr_d  = 1'b1;
        end
      end
      S_BUS: begin
        // Exit is checked first; bus_ack can only be set by an earlier
        // cmd_done, so an aborted cycle still sees exactly one ack cycle.
        if (ack_q && !bus_req) begin
          gnt_d   = 1'b0;
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end else if (done_ok) begin
          ack_d = 1'b1;
        end
      end
      S_REF: begin
        if (done_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase
  end

  // Refresh interval timer and refresh debt bookkeeping.
  always_comb begin
    tmr_d  = '0;
    pend_d = pend_q;
    ovr_d  = ovr_q | (tick & (pend_q == PEND_MAX));
    if (idone_q) begin
      tmr_d = tick ? '0 : tmr_q + RI_W'(1);
    end
    case ({tick, ref_done})
      2'b10:   pend_d = (pend_q == PEND_MAX) ? pend_q : pend_q + 4'd1;
      2'b01:   pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      state_q    <= S_INIT_WAIT;
      pw_cnt_q   <= '0;
      init_cnt_q <= '0;
      tmr_q      <= '0;
      pend_q     <= '0;
      ovr_q      <= 1'b0;
      start_q    <= 1'b0;
      refr_q     <= 1'b0;
      gnt_q      <= 1'b0;
      ack_q      <= 1'b0;
      idone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_cnt_q   <= pw_cnt_d;
      init_cnt_q <= init_cnt_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      start_q    <= start_d;
      refr_q     <= refr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      idone_q    <= idone_d;
    end
  end

  assign cmd_start   = start_q;
  assign cmd_refresh = refr_q;
  assign bus_gnt     = gnt_q;
  assign bus_ack     = ack_q;
  assign init_done   = idone_q;
  assign pending     = pend_q;
  assign ref_overrun = ovr_q;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Bench for sdram_refresh_arbiter: a behavioural model of the arbitration
// rules tracks expected outputs cycle by cycle; scenario tasks add directed
// timing checks on top of the per-cycle comparison.
module tb_sdram_refresh_arbiter;

  localparam int P       = 10;
  localparam int N       = 2;
  localparam int I       = 20;
  localparam int M       = 4;
  localparam int SEQ_LAT = 3;

  logic       MEMCLK  = 1'b0;
  logic       RESET_n = 1'b0;
  logic       bus_req = 1'b0;
  logic       cmd_done = 1'b0;
  logic       cmd_start, cmd_refresh, bus_gnt, bus_ack, init_done, ref_overrun;
  logic [3:0] pending;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // sequencer stub state
  int seq_cnt = 0;
  bit inject  = 0;

  // reference model state
  bit m_start, m_refr, m_gnt, m_ack, m_idone, m_ovr, m_gap, m_busy;
  int m_debt, m_wait, m_done_cnt, m_tcnt;

  sdram_refresh_arbiter #(
    .POWERUP_CYCLES  (P),
    .INIT_REFRESHES  (N),
    .REFRESH_INTERVAL(I),
    .MAX_PENDING     (M)
  ) dut (
    .MEMCLK     (MEMCLK),
    .RESET_n    (RESET_n),
    .bus_req    (bus_req),
    .cmd_done   (cmd_done),
    .cmd_start  (cmd_start),
    .cmd_refresh(cmd_refresh),
    .bus_gnt    (bus_gnt),
    .bus_ack    (bus_ack),
    .init_done  (init_done),
    .pending    (pending),
    .ref_overrun(ref_overrun)
  );

  always #5 MEMCLK = ~MEMCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] dut_vec();
    return {cmd_start, cmd_refresh, bus_gnt, bus_ack, init_done, pending, ref_overrun};
  endfunction

  function automatic logic [9:0] mdl_vec();
    return {m_start, m_refr, m_gnt, m_ack, m_idone, 4'(m_debt), m_ovr};
  endfunction

  // Behavioural model: one call per rising edge, using inputs as seen at it.
  task automatic model_edge();
    bit ok, tick, dec, idone_old;
    if (!RESET_n) begin
      {m_start, m_refr, m_gnt, m_ack, m_idone, m_ovr, m_gap, m_busy} = '0;
      m_debt = 0; m_wait = 0; m_done_cnt = 0; m_tcnt = 0;
      return;
    end
    idone_old = m_idone;
    ok   = cmd_done && !m_start && m_busy;
    tick = m_idone && (m_tcnt == I - 1);
    dec  = 0;
    m_start = 0;
    m_refr  = 0;
    if (!m_idone) begin
      if (m_wait < P) begin
        m_wait++;
        if (m_wait == P) begin m_start = 1; m_refr = 1; m_busy = 1; end
      end else if (m_gap) begin
        m_gap = 0; m_start = 1; m_refr = 1; m_busy = 1;
      end else if (ok) begin
        m_busy = 0;
        m_done_cnt++;
        if (m_done_cnt == N) m_idone = 1; else m_gap = 1;
      end
    end else if (m_gnt) begin
      if (m_ack && !bus_req) begin m_gnt = 0; m_ack = 0; end
      else if (ok) begin m_ack = 1; m_busy = 0; end
    end else if (m_busy) begin
      if (ok) begin m_busy = 0; dec = 1; end
    end else begin
      if (m_debt == M) begin m_start = 1; m_refr = 1; m_busy = 1; end
      else if (bus_req) begin m_start = 1; m_gnt = 1; m_busy = 1; end
      else if (m_debt > 0) begin m_start = 1; m_refr = 1; m_busy = 1; end
    end
    if (tick && m_debt == M) m_ovr = 1;
    if (tick && !dec && m_debt < M) m_debt++;
    else if (dec && !tick) m_debt--;
    m_tcnt = idone_old ? (m_tcnt + 1) % I : 0;
  endtask

  // Advance one clock: update model, then play the sequencer stub.
  task automatic step();
    @(posedge MEMCLK);
    model_edge();
    #1;
    cyc++;
    cmd_done = 1'b0;
    if (!RESET_n) begin
      seq_cnt = 0;
    end else begin
      if (seq_cnt > 0) begin
        seq_cnt--;
        if (seq_cnt == 0) cmd_done = 1'b1;
      end
      if (cmd_start) begin
        seq_cnt = SEQ_LAT;
        if (inject) begin cmd_done = 1'b1; inject = 0; end
      end
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    bus_req = 1'b1;
    repeat (3) begin
      step();
      total++;
      if (dut_vec() !== '0) $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc, dut_vec());
      else passed++;
    end
  endtask

  task automatic test_init();
    int first_s, second_s, idone_c, gnt_c;
    bit gnt_early;
    first_s = -1; second_s = -1; idone_c = -1; gnt_c = -1; gnt_early = 0;
    RESET_n = 1'b1;
    bus_req = 1'b1;
    for (int c = 1; c <= 60 && gnt_c < 0; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL init_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (cmd_start && first_s < 0) first_s = c;
      else if (cmd_start && second_s < 0) second_s = c;
      if (init_done && idone_c < 0) idone_c = c;
      if (bus_gnt && gnt_c < 0) gnt_c = c;
      if (bus_gnt && !init_done) gnt_early = 1;
    end
    total++;
    if (first_s != P) $display("FAIL init_first_start got=%0d exp=%0d", first_s, P);
    else passed++;
    total++;
    if (second_s != P + SEQ_LAT + 2) $display("FAIL init_second_start got=%0d exp=%0d", second_s, P + SEQ_LAT + 2);
    else passed++;
    total++;
    if (idone_c != P + 2 * SEQ_LAT + 3) $display("FAIL init_done_cycle got=%0d exp=%0d", idone_c, P + 2 * SEQ_LAT + 3);
    else passed++;
    total++;
    if (gnt_c != P + 2 * SEQ_LAT + 4) $display("FAIL first_grant got=%0d exp=%0d", gnt_c, P + 2 * SEQ_LAT + 4);
    else passed++;
    total++;
    if (gnt_early !== 1'b0) $display("FAIL grant_before_init got=%0d exp=0", gnt_early);
    else passed++;
    for (int c = 0; c < 8 && !m_ack; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL init_bus_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
    end
    bus_req = 1'b0;
  endtask

  task automatic test_idle_refresh();
    int prev_p, rises;
    bit want_issue;
    prev_p = int'(pending); rises = 0; want_issue = 0;
    bus_req = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL idle_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (want_issue) begin
        total++;
        if (!(cmd_start && cmd_refresh)) $display("FAIL idle_refresh_issue cyc=%0d got=%b%b exp=11", cyc, cmd_start, cmd_refresh);
        else passed++;
        want_issue = 0;
      end
      if (prev_p == 0 && pending == 4'd1) begin want_issue = 1; rises++; end
      prev_p = int'(pending);
    end
    total++;
    if (rises < 4) $display("FAIL idle_tick_count got=%0d exp>=4", rises);
    else passed++;
    total++;
    if (ref_overrun !== 1'b0) $display("FAIL idle_overrun got=%b exp=0", ref_overrun);
    else passed++;
  endtask

  task automatic test_bus_hog();
    int prev_p, ovr_pend;
    bit prev_ovr;
    prev_p = int'(pending); prev_ovr = ref_overrun; ovr_pend = -1;
    bus_req = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL hog_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (ref_overrun && !prev_ovr) ovr_pend = prev_p;
      prev_p = int'(pending);
      prev_ovr = ref_overrun;
    end
    total++;
    if (pending !== 4'(M)) $display("FAIL hog_pending got=%0d exp=%0d", pending, M);
    else passed++;
    total++;
    if (ref_overrun !== 1'b1) $display("FAIL hog_overrun got=%b exp=1", ref_overrun);
    else passed++;
    total++;
    if (ovr_pend != M) $display("FAIL hog_overrun_debt got=%0d exp=%0d", ovr_pend, M);
    else passed++;
    // one-cycle drop releases the bus; the re-asserted request must wait
    bus_req = 1'b0;
    step();
    total++;
    if (bus_gnt !== 1'b0) $display("FAIL hog_release got=%b exp=0", bus_gnt);
    else passed++;
    bus_req = 1'b1;
    step();
    total++;
    if ({cmd_start, cmd_refresh, bus_gnt} !== 3'b110) $display("FAIL forced_refresh got=%b exp=110", {cmd_start, cmd_refresh, bus_gnt});
    else passed++;
    for (int c = 0; c < 75; c++) begin
      if (c == 15) bus_req = 1'b0;
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL hog_drain_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
    end
  endtask

  task automatic test_tick_collision();
    bit found;
    found = 0;
    bus_req = 1'b0;
    for (int c = 0; c < 3 * I && !found; c++) begin
      if (m_idone && !m_gnt && !m_busy && m_debt == 0 && m_tcnt == I - 1) found = 1;
      else step();
    end
    total++;
    if (!found) $display("FAIL collision_setup got=timeout exp=idle_before_tick");
    else passed++;
    bus_req = 1'b1;
    step();
    total++;
    if ({cmd_start, cmd_refresh, bus_gnt, pending} !== {3'b101, 4'd1})
      $display("FAIL collision_grant got=%b exp=1010001", {cmd_start, cmd_refresh, bus_gnt, pending});
    else passed++;
    for (int c = 0; c < 8 && !m_ack; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL collision_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
    end
    bus_req = 1'b0;
    step();
    total++;
    if ({bus_gnt, cmd_start} !== 2'b00) $display("FAIL collision_exit got=%b exp=00", {bus_gnt, cmd_start});
    else passed++;
    step();
    total++;
    if ({cmd_start, cmd_refresh} !== 2'b11) $display("FAIL collision_late_refresh got=%b exp=11", {cmd_start, cmd_refresh});
    else passed++;
    repeat (8) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL collision_tail_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
    end
  endtask

  task automatic test_cmd_done_qual();
    int ack_c, c;
    bus_req = 1'b0;
    for (c = 0; c < 3 * I && (m_busy || m_gnt || m_debt != 0); c++) step();
    inject = 1;
    bus_req = 1'b1;
    step();
    total++;
    if ({cmd_start, cmd_refresh, cmd_done} !== 3'b101) $display("FAIL qual_setup got=%b exp=101", {cmd_start, cmd_refresh, cmd_done});
    else passed++;
    step();
    total++;
    if (bus_ack !== 1'b0) $display("FAIL qual_ignored_done got=%b exp=0", bus_ack);
    else passed++;
    ack_c = -1;
    for (c = 2; c <= 10 && ack_c < 0; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL qual_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (bus_ack) ack_c = c;
    end
    total++;
    if (ack_c != SEQ_LAT + 1) $display("FAIL qual_ack_delay got=%0d exp=%0d", ack_c, SEQ_LAT + 1);
    else passed++;
    bus_req = 1'b0;
    step();
    for (c = 0; c < 3 * I && (m_busy || m_gnt || m_debt != 0); c++) step();
    // aborted cycle: request withdrawn before the sequencer finishes
    bus_req = 1'b1;
    step();
    bus_req = 1'b0;
    ack_c = -1;
    for (c = 1; c <= 10 && ack_c < 0; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL abort_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (bus_ack) ack_c = c;
    end
    total++;
    if (ack_c != SEQ_LAT + 1 || bus_gnt !== 1'b1) $display("FAIL abort_ack got=%0d/%b exp=%0d/1", ack_c, bus_gnt, SEQ_LAT + 1);
    else passed++;
    step();
    total++;
    if ({bus_ack, bus_gnt} !== 2'b00) $display("FAIL abort_pulse got=%b exp=00", {bus_ack, bus_gnt});
    else passed++;
  endtask

  task automatic test_reset_mid_bus();
    int first_s, idone_c;
    bit hit;
    hit = 0;
    bus_req = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL prereset_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (m_gnt && m_debt == 3) hit = 1;
    end
    total++;
    if (!hit || pending !== 4'd3 || bus_gnt !== 1'b1) $display("FAIL prereset_state got=%0d/%b exp=3/1", pending, bus_gnt);
    else passed++;
    RESET_n = 1'b0;
    step();
    total++;
    if (dut_vec() !== '0) $display("FAIL midbus_reset got=%b exp=0", dut_vec());
    else passed++;
    RESET_n = 1'b1;
    bus_req = 1'b0;
    first_s = -1; idone_c = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL reinit_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
      if (cmd_start && first_s < 0) first_s = c;
      if (init_done && idone_c < 0) idone_c = c;
    end
    total++;
    if (first_s != P || idone_c != P + 2 * SEQ_LAT + 3)
      $display("FAIL reinit_timing got=%0d/%0d exp=%0d/%0d", first_s, idone_c, P, P + 2 * SEQ_LAT + 3);
    else passed++;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus_req) begin
        if ($urandom_range(0, 5) == 0) begin
          bus_req = 1'b1;
          hold = ($urandom_range(0, 29) == 0) ? int'($urandom_range(40, 120)) : int'($urandom_range(0, 6));
        end
      end else if (m_ack || (!m_gnt && $urandom_range(0, 19) == 0) || (m_gnt && !m_ack && $urandom_range(0, 15) == 0)) begin
        if (hold > 0) hold--;
        else bus_req = 1'b0;
      end
      step();
      total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL random_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), mdl_vec());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_idle_refresh();
    test_bus_hog();
    test_tick_collision();
    test_cmd_done_qual();
    test_reset_mid_bus();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
